// File: rtl/pc_seq_pkg.sv
// Shared encodings for the fetch / next-PC sequencer.
// States, error codes, PC increment and the redirect buffer type.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ALIGN   = 2'b10;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic        valid;
    logic [31:0] alvo;
  } pend_t;

  function automatic logic misaligned(
    input logic [31:0] a
  );
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_seq_timeout.sv
// Fetch wait-cycle counter for the PC sequencer.
// expired flags that the current unanswered cycle is the TIMEOUT-th one.
module pc_seq_timeout #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [3:0] LIMIT = 4'(TIMEOUT);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Looking one count ahead lets ready on the last cycle still win.
  assign expired = (cnt + 4'd1) == LIMIT;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/next-PC controller: imem handshake, redirect buffering,
// stall, halt, fetch timeout and misaligned-target fault.
import pc_seq_pkg::*;

module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] atual_Pc,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic [31:0] branch_alvo,
  input  logic        jump,
  input  logic [31:0] jump_alvo,
  output logic [31:0] proximo_Pc,
  output logic        imem_req,
  output logic        instr_valid,
  output logic [1:0]  erro,
  output logic [1:0]  estado
);

  state_t      st_q, st_d;
  logic [1:0]  err_q, err_d;
  pend_t       pend_q, pend_d;
  logic        to_clr, to_inc, to_exp;
  logic [31:0] tgt;

  pc_seq_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (to_clr),
    .inc    (to_inc),
    .expired(to_exp)
  );

  always_comb begin
    tgt = atual_Pc + PC_INC;
    priority case (1'b1)
      jump:         tgt = jump_alvo;
      branch_taken: tgt = branch_alvo;
      pend_q.valid: tgt = pend_q.alvo;
      default:      tgt = atual_Pc + PC_INC;
    endcase
  end

  always_comb begin
    st_d       = st_q;
    err_d      = err_q;
    pend_d     = pend_q;
    proximo_Pc = atual_Pc;
    to_clr     = 1'b0;
    to_inc     = 1'b0;
    unique case (st_q)
      ST_BOOT: begin
        proximo_Pc = RESET_VEC;
        st_d       = ST_FETCH;
        to_clr     = 1'b1;
      end
      ST_FETCH: begin
        if (jump) begin
          pend_d = '{valid: 1'b1, alvo: jump_alvo};
        end else if (branch_taken) begin
          pend_d = '{valid: 1'b1, alvo: branch_alvo};
        end
        if (imem_ready) begin
          st_d   = ST_EXEC;
          to_clr = 1'b1;
        end else if (to_exp) begin
          st_d = ST_HALTED;
          if (err_q == ERR_NONE) err_d = ERR_TIMEOUT;
        end else begin
          to_inc = 1'b1;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          pend_d.valid = 1'b0;
          if (misaligned(tgt)) begin
            st_d = ST_HALTED;
            if (err_q == ERR_NONE) err_d = ERR_ALIGN;
          end else if (halt) begin
            st_d = ST_HALTED;
          end else begin
            proximo_Pc = tgt;
            st_d       = ST_FETCH;
          end
        end
      end
      ST_HALTED: begin
        st_d = ST_HALTED;
      end
      default: begin
        st_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= ST_BOOT;
      err_q  <= ERR_NONE;
      pend_q <= '0;
    end else begin
      st_q   <= st_d;
      err_q  <= err_d;
      pend_q <= pend_d;
    end
  end

  assign imem_req    = (st_q == ST_FETCH);
  assign instr_valid = (st_q == ST_EXEC);
  assign erro        = err_q;
  assign estado      = st_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: cycle model plus
// directed scenarios with hand-computed expectations.
module tb_pc_sequencer;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] atual_Pc = 32'h0;
  logic        imem_ready = 1'b1;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_alvo = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_alvo = 32'h0;
  logic [31:0] proximo_Pc;
  logic        imem_req;
  logic        instr_valid;
  logic [1:0]  erro;
  logic [1:0]  estado;

  int n_cmp = 0;
  int n_bad = 0;

  pc_sequencer #(
    .RESET_VEC(32'h0),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .atual_Pc    (atual_Pc),
    .imem_ready  (imem_ready),
    .stall       (stall),
    .halt        (halt),
    .branch_taken(branch_taken),
    .branch_alvo (branch_alvo),
    .jump        (jump),
    .jump_alvo   (jump_alvo),
    .proximo_Pc  (proximo_Pc),
    .imem_req    (imem_req),
    .instr_valid (instr_valid),
    .erro        (erro),
    .estado      (estado)
  );

  always #5 clk = ~clk;

  // the pc register the sequencer feeds
  always @(posedge clk) atual_Pc <= proximo_Pc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: mode 0 boot, 1 fetch, 2 exec, 3 halted
  int          m_st, n_st, m_cnt, n_cnt;
  logic [1:0]  m_err, n_err;
  logic        m_pv, n_pv;
  logic [31:0] m_pa, n_pa;
  bit          m_go;

  task automatic m_reset();
    m_st = 0; m_err = 2'b00; m_pv = 1'b0; m_pa = 32'h0;
    m_cnt = 0; m_go = 1'b0;
  endtask

  initial m_reset();
  always @(negedge rst) m_reset();

  always @(negedge clk) begin : model
    logic [31:0] e_pc;
    logic [31:0] t;
    if (rst) begin
      n_st = m_st; n_err = m_err; n_pv = m_pv;
      n_pa = m_pa; n_cnt = m_cnt; e_pc = atual_Pc;
      case (m_st)
        0: begin
          e_pc = 32'h0;
          n_st = 1;
        end
        1: begin
          if (jump) begin
            n_pv = 1'b1; n_pa = jump_alvo;
          end else if (branch_taken) begin
            n_pv = 1'b1; n_pa = branch_alvo;
          end
          if (imem_ready) begin
            n_st = 2; n_cnt = 0;
          end else if (m_cnt + 1 == TO) begin
            n_st = 3;
            if (m_err == 2'b00) n_err = 2'b01;
          end else begin
            n_cnt = m_cnt + 1;
          end
        end
        2: begin
          if (!stall) begin
            if (jump) t = jump_alvo;
            else if (branch_taken) t = branch_alvo;
            else if (m_pv) t = m_pa;
            else t = atual_Pc + 32'd4;
            n_pv = 1'b0;
            if (t[1:0] != 2'b00) begin
              n_st = 3;
              if (m_err == 2'b00) n_err = 2'b10;
            end else if (halt) begin
              n_st = 3;
            end else begin
              n_st = 1; e_pc = t;
            end
          end
        end
        default: ;
      endcase
      chk("m_proximo_Pc", proximo_Pc, e_pc);
      chk("m_imem_req", imem_req, m_st == 1);
      chk("m_instr_valid", instr_valid, m_st == 2);
      chk("m_erro", erro, m_err);
      chk("m_estado", estado, m_st);
      m_go = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst && m_go) begin
      m_st = n_st; m_err = n_err; m_pv = n_pv;
      m_pa = n_pa; m_cnt = n_cnt;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic wait_st(input logic [1:0] s);
    int k = 0;
    neg();
    while (estado !== s && k < 60) begin
      neg();
      k++;
    end
    if (estado !== s) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_state: estado %0d want %0d", estado, s);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // reset and boot, zero-wait memory
    rst = 1'b0;
    nxt(); nxt(); neg();
    chk("rst_estado", estado, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_iv", instr_valid, 0);
    chk("rst_erro", erro, 0);
    nxt(); rst = 1'b1; neg();
    chk("boot_pc", proximo_Pc, 32'h0);
    chk("boot_estado", estado, 0);
    nxt(); neg();
    chk("f0_req", imem_req, 1);
    chk("f0_pc", atual_Pc, 32'h0);
    nxt(); neg();
    chk("e0_iv", instr_valid, 1);
    chk("e0_next", proximo_Pc, 32'h4);
    nxt(); neg();
    chk("f1_pc", atual_Pc, 32'h4);
    chk("f1_iv", instr_valid, 0);
    nxt(); neg();
    chk("e1_next", proximo_Pc, 32'h8);
    nxt(); neg();
    chk("f2_pc", atual_Pc, 32'h8);
    nxt(); neg();

    // wait states: three unanswered fetch cycles
    nxt(); imem_ready = 1'b0; neg();
    chk("ws_req1", imem_req, 1);
    chk("ws_hold", proximo_Pc, 32'hC);
    nxt(); neg();
    chk("ws_req2", imem_req, 1);
    nxt(); neg();
    chk("ws_req3", imem_req, 1);
    nxt(); imem_ready = 1'b1; neg();
    chk("ws_req4", imem_req, 1);
    chk("ws_hold4", proximo_Pc, 32'hC);
    nxt(); neg();
    chk("ws_exec", instr_valid, 1);
    chk("ws_erro", erro, 0);

    // jump captured mid-fetch, applied in exec
    nxt(); imem_ready = 1'b0; jump = 1'b1; jump_alvo = 32'h40; neg();
    nxt(); jump = 1'b0; imem_ready = 1'b1; neg();
    nxt(); neg();
    chk("buf_next", proximo_Pc, 32'h40);
    nxt(); neg();
    chk("buf_pc", atual_Pc, 32'h40);

    // stall, then jump beats branch
    nxt(); stall = 1'b1; neg();
    chk("stall1_pc", proximo_Pc, 32'h40);
    nxt(); neg();
    chk("stall2_pc", proximo_Pc, 32'h40);
    chk("stall2_st", estado, 2);
    nxt(); stall = 1'b0; jump = 1'b1; jump_alvo = 32'h80;
    branch_taken = 1'b1; branch_alvo = 32'h20; neg();
    chk("prio", proximo_Pc, 32'h80);
    nxt(); jump = 1'b0; branch_taken = 1'b0; neg();

    // wrap-around of the sequential increment
    nxt(); jump = 1'b1; jump_alvo = 32'hFFFF_FFFC; neg();
    chk("jmp_top", proximo_Pc, 32'hFFFF_FFFC);
    nxt(); jump = 1'b0; neg();
    nxt(); neg();
    chk("wrap", proximo_Pc, 32'h0);
    nxt(); neg();

    // halt, then redirects ignored
    nxt(); halt = 1'b1; neg();
    chk("halt_pc", proximo_Pc, 32'h0);
    nxt(); halt = 1'b0; neg();
    chk("halt_st", estado, 3);
    chk("halt_req", imem_req, 0);
    nxt(); jump = 1'b1; jump_alvo = 32'h100; neg();
    chk("halt_ign", proximo_Pc, 32'h0);
    nxt(); jump = 1'b0; neg();
    chk("halt_stay", estado, 3);

    // async reset between edges while fetching
    rst = 1'b0;
    nxt(); rst = 1'b1; neg();
    nxt(); imem_ready = 1'b0; neg();
    chk("ar_pre_req", imem_req, 1);
    #2; rst = 1'b0; #1;
    chk("ar_req", imem_req, 0);
    chk("ar_st", estado, 0);
    chk("ar_iv", instr_valid, 0);

    // ready on the 15th wait cycle still wins
    nxt(); nxt(); rst = 1'b1;
    wait_st(2'd1);
    for (int i = 2; i <= 14; i++) begin
      nxt(); neg();
    end
    nxt(); imem_ready = 1'b1; neg();
    chk("tw_req15", imem_req, 1);
    nxt(); imem_ready = 1'b0; neg();
    chk("tw_st", estado, 2);
    chk("tw_erro", erro, 0);

    // full timeout
    cnt = 0;
    nxt(); neg();
    while (imem_req === 1'b1 && cnt < 40) begin
      cnt++;
      nxt(); neg();
    end
    chk("to_cycles", cnt, 15);
    chk("to_erro", erro, 2'b01);
    chk("to_st", estado, 3);

    // misaligned branch target
    rst = 1'b0;
    nxt(); imem_ready = 1'b1; rst = 1'b1;
    wait_st(2'd1);
    nxt(); branch_taken = 1'b1; branch_alvo = 32'h102; neg();
    chk("mis_pc", proximo_Pc, 32'h0);
    nxt(); branch_taken = 1'b0; neg();
    chk("mis_erro", erro, 2'b10);
    chk("mis_st", estado, 3);
    nxt(); jump = 1'b1; jump_alvo = 32'h3; neg();
    nxt(); jump = 1'b0; neg();
    chk("mis_sticky", erro, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
